// File: rtl/mig_ctrl_wr.sv
// mig_ctrl_wr: burst write engine for the MIG native user interface.
// Takes a (start address, beat count) request, pops user data through a
// first-word-fall-through strobe and drives the app/wdf write channels.
// Optional feature macro: MIG_WR_TIMEOUT_EN adds a stall watchdog and the
// wr_timeout status output.
module mig_ctrl_wr #(
  parameter int ADDR_W      = 28,
  parameter int DATA_W      = 128,
  parameter int LEN_W       = 16,
  parameter int ADDR_STEP   = 8,
  parameter int MAX_LEAD    = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                ui_clk,
  input  logic                rst,
  input  logic                wr_req,
  input  logic [ADDR_W-1:0]   wr_req_addr,
  input  logic [LEN_W-1:0]    wr_length,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                wr_data_req,
  output logic                wr_busy,
  output logic                wr_done,
`ifdef MIG_WR_TIMEOUT_EN
  output logic                wr_timeout,
`endif
  output logic [ADDR_W-1:0]   app_wr_addr,
  output logic [2:0]          app_wr_cmd,
  output logic                app_wr_en,
  input  logic                app_rdy,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  input  logic                app_wdf_rdy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state_r;
  logic [LEN_W-1:0]    len_r;
  logic [LEN_W-1:0]    cnt_data_r;
  logic [LEN_W-1:0]    cnt_cmd_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                busy_r;
  logic                done_r;

  logic [LEN_W-1:0]    lead_s;
  logic                wren_s;
  logic                cmd_en_s;
  logic                cmd_fire_s;
  logic                last_cmd_s;

`ifdef MIG_WR_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0]  stall_r;
  logic                timeout_r;
`endif

  // Channel enables: data may run ahead of commands by at most MAX_LEAD beats,
  // and a command is only offered for a beat the MIG has already taken.
  always_comb begin
    lead_s     = cnt_data_r - cnt_cmd_r;
    wren_s     = 1'b0;
    cmd_en_s   = 1'b0;
    cmd_fire_s = 1'b0;
    last_cmd_s = 1'b0;
    if (state_r == ST_WRITE) begin
      wren_s     = app_wdf_rdy && (cnt_data_r < len_r) && (lead_s < LEN_W'(MAX_LEAD));
      cmd_en_s   = (cnt_cmd_r < cnt_data_r);
      cmd_fire_s = cmd_en_s && app_rdy;
      last_cmd_s = cmd_fire_s && (cnt_cmd_r == (len_r - LEN_W'(1)));
    end else begin
      wren_s     = 1'b0;
      cmd_en_s   = 1'b0;
      cmd_fire_s = 1'b0;
      last_cmd_s = 1'b0;
    end
  end

  // Burst sequencer: request latch, beat/command counters, address walk, status.
  always_ff @(posedge ui_clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      len_r      <= '0;
      cnt_data_r <= '0;
      cnt_cmd_r  <= '0;
      addr_r     <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
`ifdef MIG_WR_TIMEOUT_EN
      stall_r    <= '0;
      timeout_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (wr_req && (wr_length != '0)) begin
            len_r      <= wr_length;
            addr_r     <= wr_req_addr;
            cnt_data_r <= '0;
            cnt_cmd_r  <= '0;
            busy_r     <= 1'b1;
            state_r    <= ST_WRITE;
`ifdef MIG_WR_TIMEOUT_EN
            stall_r    <= '0;
            timeout_r  <= 1'b0;
`endif
          end
        end
        ST_WRITE: begin
          if (wren_s) begin
            cnt_data_r <= cnt_data_r + LEN_W'(1);
          end
          if (cmd_fire_s) begin
            cnt_cmd_r <= cnt_cmd_r + LEN_W'(1);
            addr_r    <= addr_r + ADDR_W'(ADDR_STEP);
          end
          if (last_cmd_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end
`ifdef MIG_WR_TIMEOUT_EN
          else if (wren_s || cmd_fire_s) begin
            stall_r <= '0;
          end else if (stall_r == STALL_W'(TIMEOUT_CYC - 1)) begin
            stall_r   <= stall_r + STALL_W'(1);
            timeout_r <= 1'b1;
            state_r   <= ST_DONE;
            done_r    <= 1'b1;
          end else begin
            stall_r <= stall_r + STALL_W'(1);
          end
`endif
        end
        ST_DONE: begin
          done_r     <= 1'b0;
          busy_r     <= 1'b0;
          cnt_data_r <= '0;
          cnt_cmd_r  <= '0;
          state_r    <= ST_IDLE;
`ifdef MIG_WR_TIMEOUT_EN
          stall_r    <= '0;
`endif
        end
        default: begin
          state_r    <= ST_IDLE;
          cnt_data_r <= '0;
          cnt_cmd_r  <= '0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  // The wdf handshake must follow app_wdf_rdy in the same cycle, so the
  // enables are decoded from registered state; everything else is a flop.
  assign wr_data_req  = wren_s;
  assign app_wdf_wren = wren_s;
  assign app_wdf_end  = wren_s;
  assign app_wdf_data = wr_data;
  assign app_wdf_mask = '0;
  assign app_wr_cmd   = 3'b000;
  assign app_wr_en    = cmd_en_s;
  assign app_wr_addr  = addr_r;
  assign wr_busy      = busy_r;
  assign wr_done      = done_r;
`ifdef MIG_WR_TIMEOUT_EN
  assign wr_timeout   = timeout_r;
`endif

endmodule

// File: tb/tb_mig_ctrl_wr.sv
// Directed self-checking bench for mig_ctrl_wr. Inputs change on the falling
// edge; outputs are observed 1 ns later, well away from the rising edge.
module tb_mig_ctrl_wr;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int LEN_W  = 16;

  logic                ui_clk = 1'b0;
  logic                rst;
  logic                wr_req;
  logic [ADDR_W-1:0]   wr_req_addr;
  logic [LEN_W-1:0]    wr_length;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_data_req;
  logic                wr_busy;
  logic                wr_done;
  logic [ADDR_W-1:0]   app_wr_addr;
  logic [2:0]          app_wr_cmd;
  logic                app_wr_en;
  logic                app_rdy;
  logic [DATA_W-1:0]   app_wdf_data;
  logic                app_wdf_wren;
  logic                app_wdf_end;
  logic [DATA_W/8-1:0] app_wdf_mask;
  logic                app_wdf_rdy;
`ifdef MIG_WR_TIMEOUT_EN
  logic                wr_timeout;
`endif

  int n_vec = 0;
  int n_err = 0;

  // per-burst observation log
  int                n_beats;
  int                n_cmds;
  int                n_done;
  int                data_idx;
  logic              pop;
  logic [DATA_W-1:0] beat_log [0:15];
  logic [ADDR_W-1:0] cmd_log  [0:15];

  mig_ctrl_wr #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
    .ADDR_STEP(8), .MAX_LEAD(4), .TIMEOUT_CYC(16)
  ) dut (
    .ui_clk(ui_clk), .rst(rst),
    .wr_req(wr_req), .wr_req_addr(wr_req_addr), .wr_length(wr_length),
    .wr_data(wr_data), .wr_data_req(wr_data_req),
    .wr_busy(wr_busy), .wr_done(wr_done),
`ifdef MIG_WR_TIMEOUT_EN
    .wr_timeout(wr_timeout),
`endif
    .app_wr_addr(app_wr_addr), .app_wr_cmd(app_wr_cmd), .app_wr_en(app_wr_en),
    .app_rdy(app_rdy), .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy)
  );

  always #5 ui_clk = ~ui_clk;

  function automatic logic [DATA_W-1:0] pattern(input int idx);
    return {96'h0DECAF00_00000000_00000000, 32'(idx)};
  endfunction

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    n_beats  = 0;
    n_cmds   = 0;
    n_done   = 0;
    data_idx = 0;
    pop      = 1'b0;
    wr_data  = pattern(0);
  endtask

  // settle after input changes and log this cycle's handshakes
  task automatic look();
    #1;
    pop = wr_data_req;
    if (app_wdf_wren && n_beats < 16) beat_log[n_beats] = app_wdf_data;
    if (app_wdf_wren) n_beats++;
    if (app_wr_en && app_rdy && n_cmds < 16) cmd_log[n_cmds] = app_wr_addr;
    if (app_wr_en && app_rdy) n_cmds++;
    if (wr_done) n_done++;
  endtask

  // advance to the next falling edge; present the next FWFT word after a pop
  task automatic next();
    @(posedge ui_clk);
    @(negedge ui_clk);
    if (pop) begin
      data_idx++;
      wr_data = pattern(data_idx);
    end
  endtask

  task automatic run_idle(input string tag, input int budget);
    int n;
    n = 0;
    look();
    while (wr_busy && n < budget) begin
      next();
      look();
      n++;
    end
    chk(tag, wr_busy, 1'b0);
    next();
  endtask

  task automatic start(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len);
    clear_log();
    wr_req      = 1'b1;
    wr_req_addr = a;
    wr_length   = len;
    look();
    next();
    wr_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] t1_addr [0:3];
    logic [ADDR_W-1:0] t6_addr [0:1];
    t1_addr = '{28'h0000100, 28'h0000108, 28'h0000110, 28'h0000118};
    t6_addr = '{28'h0000040, 28'h0000048};

    rst = 1'b1; wr_req = 1'b0; wr_req_addr = '0; wr_length = '0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    clear_log();
    repeat (3) @(negedge ui_clk);
    rst = 1'b0;
    look();
    chk("rst_busy", wr_busy, 1'b0);
    chk("rst_done", wr_done, 1'b0);
    chk("rst_wren", app_wdf_wren, 1'b0);
    chk("rst_en", app_wr_en, 1'b0);
    chk("rst_addr", app_wr_addr, 28'h0);
    chk("rst_cmd", app_wr_cmd, 3'b000);
    chk("rst_mask", app_wdf_mask, 16'h0);
    next();

    // 1: N=4 at 0x100, both readies high: exact cycle timeline
    start(28'h0000100, 16'd4);
    for (int c = 1; c <= 7; c++) begin
      look();
      chk("t1_wren", app_wdf_wren, (c >= 1 && c <= 4));
      chk("t1_end", app_wdf_end, (c >= 1 && c <= 4));
      chk("t1_en", app_wr_en, (c >= 2 && c <= 5));
      chk("t1_done", wr_done, (c == 6));
      chk("t1_busy", wr_busy, (c >= 1 && c <= 6));
      if (c >= 2 && c <= 5) chk("t1_addr", app_wr_addr, t1_addr[c-2]);
      next();
    end
    chk("t1_beats", n_beats, 4);
    chk("t1_cmds", n_cmds, 4);
    chk("t1_ndone", n_done, 1);
    for (int i = 0; i < 4; i++) chk("t1_data", beat_log[i], pattern(i));

    // 2: N=8, app_wdf_rdy low for cycles 4..6
    start(28'h0000000, 16'd8);
    for (int c = 1; c <= 6; c++) begin
      app_wdf_rdy = !(c >= 4);
      look();
      if (c >= 4) chk("t2_req_low", wr_data_req, 1'b0);
      next();
    end
    app_wdf_rdy = 1'b1;
    run_idle("t2_finish", 40);
    chk("t2_beats", n_beats, 8);
    chk("t2_cmds", n_cmds, 8);
    chk("t2_ndone", n_done, 1);
    for (int i = 0; i < 8; i++) chk("t2_data", beat_log[i], pattern(i));
    for (int i = 0; i < 8; i++) chk("t2_addr", cmd_log[i], 28'h0000000 + 28'(8 * i));

    // 3: N=8, app_rdy low for cycles 1..10: lead capped at 4 beats
    app_rdy = 1'b0;
    start(28'h0000200, 16'd8);
    for (int c = 1; c <= 10; c++) begin
      look();
      if (c >= 5) chk("t3_wren_stall", app_wdf_wren, 1'b0);
      if (c >= 2) chk("t3_en_held", app_wr_en, 1'b1);
      if (c >= 2) chk("t3_addr_stable", app_wr_addr, 28'h0000200);
      next();
    end
    chk("t3_beats_lead", n_beats, 4);
    chk("t3_cmds_none", n_cmds, 0);
    app_rdy = 1'b1;
    run_idle("t3_finish", 40);
    chk("t3_beats", n_beats, 8);
    chk("t3_cmds", n_cmds, 8);
    chk("t3_ndone", n_done, 1);
    for (int i = 0; i < 8; i++) chk("t3_addr", cmd_log[i], 28'h0000200 + 28'(8 * i));

    // 4a: zero-length request is ignored
    start(28'h0000500, 16'd0);
    for (int c = 1; c <= 3; c++) begin
      look();
      chk("t4_busy", wr_busy, 1'b0);
      chk("t4_wren", app_wdf_wren, 1'b0);
      chk("t4_en", app_wr_en, 1'b0);
      next();
    end
    // 4b: request while busy does not reload the address
    start(28'h0000300, 16'd4);
    wr_req = 1'b1; wr_req_addr = 28'h0000700; wr_length = 16'd4;
    look(); next();
    look(); next();
    wr_req = 1'b0;
    run_idle("t4_finish", 40);
    chk("t4_beats", n_beats, 4);
    chk("t4_cmds", n_cmds, 4);
    chk("t4_addr0", cmd_log[0], 28'h0000300);
    chk("t4_addr3", cmd_log[3], 28'h0000318);
    look();
    chk("t4_no_restart", wr_busy, 1'b0);
    next();

    // 5: address wrap
    start(28'hFFFFFF8, 16'd2);
    run_idle("t5_finish", 20);
    chk("t5_cmds", n_cmds, 2);
    chk("t5_addr0", cmd_log[0], 28'hFFFFFF8);
    chk("t5_addr1", cmd_log[1], 28'h0000000);

    // 6: reset mid-burst at beat 3, then a normal N=2 burst
    start(28'h0000080, 16'd8);
    look(); next();
    look(); next();
    rst = 1'b1;
    #1;
    chk("t6_rst_wren", app_wdf_wren, 1'b0);
    chk("t6_rst_en", app_wr_en, 1'b0);
    chk("t6_rst_busy", wr_busy, 1'b0);
    chk("t6_rst_done", wr_done, 1'b0);
    chk("t6_rst_addr", app_wr_addr, 28'h0);
    @(negedge ui_clk);
    rst = 1'b0;
    clear_log();
    for (int c = 0; c < 5; c++) begin
      look(); next();
    end
    chk("t6_no_done", n_done, 0);
    chk("t6_no_beats", n_beats, 0);
    start(28'h0000040, 16'd2);
    run_idle("t6_finish", 20);
    chk("t6_cmds", n_cmds, 2);
    chk("t6_ndone", n_done, 1);
    chk("t6_addr0", cmd_log[0], t6_addr[0]);
    chk("t6_addr1", cmd_log[1], t6_addr[1]);

`ifdef MIG_WR_TIMEOUT_EN
    // 7: data ready stuck low -> timeout after 16 stall cycles
    app_wdf_rdy = 1'b0;
    start(28'h0000000, 16'd4);
    for (int c = 1; c <= 16; c++) begin
      look();
      chk("t7_no_done_yet", wr_done, 1'b0);
      next();
    end
    look();
    chk("t7_done", wr_done, 1'b1);
    chk("t7_timeout", wr_timeout, 1'b1);
    next();
    look(); next();
    look();
    chk("t7_sticky", wr_timeout, 1'b1);
    next();
    app_wdf_rdy = 1'b1;
    start(28'h0000000, 16'd1);
    look();
    chk("t7_cleared", wr_timeout, 1'b0);
    next();
    run_idle("t7_finish", 20);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mig_ctrl_wr.md
Name: mig_ctrl_wr

Overview:
Write-side companion to the MIG read controller. It accepts a burst write request (start address, length in 128-bit beats) and pulls user data through a first-word-fall-through style request strobe. It drives the MIG native app/wdf write channels and pulses wr_done after the last command is accepted. It sits between the frame/data source logic and the MIG user interface, clocked by ui_clk.

Parameters:
ADDR_W, 28, MIG app address width
DATA_W, 128, app_wdf_data width (one beat per BL8 burst, 4:1 ratio)
LEN_W, 16, burst length counter width
ADDR_STEP, 8, address increment per accepted command
MAX_LEAD, 4, maximum data beats accepted ahead of accepted commands
TIMEOUT_CYC, 1024, stall limit; used only with the optional feature

Ports:
ui_clk  in  1  MIG user clock; all logic on its rising edge
rst  in  1  reset, asynchronous, active-high
wr_req  in  1  start request; sampled only in IDLE
wr_req_addr  in  ADDR_W  burst start address
wr_length  in  LEN_W  number of beats (commands) in the burst
wr_data  in  DATA_W  user write data; must be valid in the same cycle as wr_data_req
wr_data_req  out  1  user data pop strobe; equals app_wdf_wren
wr_busy  out  1  high in WRITE and DONE
wr_done  out  1  one-cycle pulse at burst completion
app_wr_addr  out  ADDR_W  MIG app_addr
app_wr_cmd  out  3  MIG app_cmd; constant 3'b000 (write)
app_wr_en  out  1  MIG app_en
app_rdy  in  1  MIG command ready
app_wdf_data  out  DATA_W  MIG write data; equals wr_data
app_wdf_wren  out  1  MIG write data enable
app_wdf_end  out  1  equals app_wdf_wren (single beat per burst)
app_wdf_mask  out  DATA_W/8  constant 0
app_wdf_rdy  in  1  MIG write data ready

Behaviour:
- Reset: asynchronous. State goes to IDLE. Counters, latched length and app_wr_addr are cleared to 0. wr_busy, wr_done, wr_data_req, app_wr_en and app_wdf_wren are 0. Reset asserted mid-burst aborts the burst; no wr_done is issued.
- State IDLE: if wr_req=1 and wr_length!=0, latch wr_length and load app_wr_addr=wr_req_addr, then go to WRITE. wr_req with wr_length=0 is ignored.
- wr_req in WRITE or DONE is ignored.
- State WRITE, data channel:
  - app_wdf_wren = app_wdf_rdy && cnt_data<len && (cnt_data-cnt_cmd)<MAX_LEAD.
  - cnt_data increments on each app_wdf_wren.
- State WRITE, command channel:
  - app_wr_en = (cnt_cmd<cnt_data). A command is issued only for a beat already accepted, which is legal for MIG (data before command).
  - app_wr_en stays high with app_wr_addr stable until app_rdy=1.
  - On app_wr_en && app_rdy: cnt_cmd increments and app_wr_addr += ADDR_STEP, modulo 2^ADDR_W.
- Data and command handshakes may occur in the same cycle; the two channels are independent.
- When the command with cnt_cmd==len-1 is accepted, go to DONE.
- State DONE: wr_done=1 for one cycle, wr_busy=1. Then go to IDLE with counters cleared.
- Latency with app_rdy=app_wdf_rdy=1, request at cycle 0:
  - data beats at cycles 1..N
  - commands at cycles 2..N+1
  - wr_done at cycle N+2
- Counter arithmetic is LEN_W-bit unsigned. The difference cnt_data-cnt_cmd never exceeds MAX_LEAD.

Optional Feature:
MIG_WR_TIMEOUT_EN
- Defined:
  - Adds output port wr_timeout (1 bit).
  - A stall counter clears on any data or command handshake and on entry to WRITE. It increments in every other WRITE cycle.
  - When the counter reaches TIMEOUT_CYC, the block sets wr_timeout (sticky, cleared by the next accepted wr_req or by reset) and goes to DONE; wr_done pulses.
- Undefined: the port and counter are absent, and WRITE waits indefinitely.

Test Plan:
- N=4, addr 0x0000100, both readies held at 1 -> wren at cycles 1-4; app_wr_addr 0x100/0x108/0x110/0x118 accepted at cycles 2-5; wr_done pulse at cycle 6 only; wr_busy high for cycles 1-6.
- N=8, app_wdf_rdy low for 3 cycles mid-burst -> wr_data_req low in those cycles; exactly 8 beats and 8 commands; data order preserved on app_wdf_data.
- N=8, MAX_LEAD=4, app_rdy low for 10 cycles -> exactly 4 beats accepted, then wren stalls; app_wr_en held high with app_wr_addr stable; burst completes once app_rdy=1.
- wr_length=0 request -> wr_busy stays 0, no app activity; a second wr_req while busy -> ignored, no address reload.
- Start address 0xFFFFFF8, N=2 -> command addresses 0xFFFFFF8 then 0x0000000.
- rst pulsed at beat 3 of N=8 -> all outputs 0 immediately, no wr_done; next request (N=2) completes normally. With MIG_WR_TIMEOUT_EN, TIMEOUT_CYC=16 and app_wdf_rdy stuck low -> wr_timeout=1 and wr_done pulse after 16 stall cycles.
